// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake between the decode stage (master) and alu_issue_ctrl (slave).
interface alu_issue_ctrl_if #(
   parameter int XLEN = 64
);
   logic            req_valid;
   logic            req_ready;
   logic [1:0]      req_aluop;
   logic [2:0]      req_funct3;
   logic            req_funct7_5;
   logic [XLEN-1:0] req_op1;
   logic [XLEN-1:0] req_op2;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [XLEN-1:0] rsp_result;
   logic            rsp_taken;
   logic            rsp_error;

   modport master (
      output req_valid, req_aluop, req_funct3, req_funct7_5, req_op1, req_op2, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_taken, rsp_error
   );

   modport slave (
      input  req_valid, req_aluop, req_funct3, req_funct7_5, req_op1, req_op2, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_taken, rsp_error
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded operation at a time to the combinational ALU and returns result,
// branch decision and illegal-op flag over a valid/ready response.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request; accept latches operands and decoded code
// EXEC  | ALU inputs stable for one cycle; result and branch decision captured at the edge
// RESP  | rsp_valid=1, response held until rsp_ready
module alu_issue_ctrl #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   alu_issue_ctrl_if.slave bus,
   output logic [XLEN-1:0] alu_input1,
   output logic [XLEN-1:0] alu_input2,
   output logic [3:0]      alu_control,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_zero
);

   localparam logic [3:0] CTL_AND = 4'b0000;
   localparam logic [3:0] CTL_OR  = 4'b0001;
   localparam logic [3:0] CTL_ADD = 4'b0010;
   localparam logic [3:0] CTL_SUB = 4'b0110;
   localparam logic [3:0] CTL_SLT = 4'b0111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_EQ   = 3'd1,
      BR_NE   = 3'd2,
      BR_LT   = 3'd3,
      BR_GE   = 3'd4
   } br_kind_t;

   state_t          state;
   state_t          state_nxt;
   logic            accept;

   logic [3:0]      dec_code;
   br_kind_t        dec_br;
   logic            dec_illegal;

   br_kind_t        br_kind;
   logic            taken_calc;

   logic [XLEN-1:0] rsp_result_q;
   logic            rsp_taken_q;
   logic            rsp_error_q;

   always_comb begin
      dec_code    = CTL_ADD;
      dec_br      = BR_NONE;
      dec_illegal = 1'b0;
      case (bus.req_aluop)
         2'b00: dec_code = CTL_ADD;
         2'b01: begin
            case (bus.req_funct3)
               3'b000: begin dec_code = CTL_SUB; dec_br = BR_EQ; end
               3'b001: begin dec_code = CTL_SUB; dec_br = BR_NE; end
               3'b100: begin dec_code = CTL_SLT; dec_br = BR_LT; end
               3'b101: begin dec_code = CTL_SLT; dec_br = BR_GE; end
               default: dec_illegal = 1'b1;
            endcase
         end
         2'b10: begin
            case (bus.req_funct3)
               3'b000: dec_code = bus.req_funct7_5 ? CTL_SUB : CTL_ADD;
               3'b111: begin dec_code = CTL_AND; dec_illegal = bus.req_funct7_5; end
               3'b110: begin dec_code = CTL_OR;  dec_illegal = bus.req_funct7_5; end
               3'b010: begin dec_code = CTL_SLT; dec_illegal = bus.req_funct7_5; end
               default: dec_illegal = 1'b1;
            endcase
         end
         default: dec_illegal = 1'b1;
      endcase
      // Illegal ops still drive the ALU, but with a neutral AND code and no branch kind.
      if (dec_illegal) begin
         dec_code = CTL_AND;
         dec_br   = BR_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      accept        = 1'b0;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               accept    = 1'b1;
               state_nxt = dec_illegal ? RESP : EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      taken_calc = 1'b0;
      case (br_kind)
         BR_EQ:   taken_calc = alu_zero;
         BR_NE:   taken_calc = !alu_zero;
         BR_LT:   taken_calc = alu_result[0];
         BR_GE:   taken_calc = !alu_result[0];
         default: taken_calc = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_input1   <= '0;
         alu_input2   <= '0;
         alu_control  <= CTL_AND;
         br_kind      <= BR_NONE;
         rsp_result_q <= '0;
         rsp_taken_q  <= 1'b0;
         rsp_error_q  <= 1'b0;
      end else begin
         if (accept) begin
            alu_input1  <= bus.req_op1;
            alu_input2  <= bus.req_op2;
            alu_control <= dec_code;
            br_kind     <= dec_br;
            if (dec_illegal) begin
               rsp_result_q <= '0;
               rsp_taken_q  <= 1'b0;
               rsp_error_q  <= 1'b1;
            end
         end
         if (state == EXEC) begin
            rsp_result_q <= alu_result;
            rsp_taken_q  <= taken_calc;
            rsp_error_q  <= 1'b0;
         end
      end
   end

   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_taken  = rsp_taken_q;
   assign bus.rsp_error  = rsp_error_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;
   localparam int XLEN = 64;

   logic            clk;
   logic            reset;
   logic [XLEN-1:0] alu_input1;
   logic [XLEN-1:0] alu_input2;
   logic [3:0]      alu_control;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;

   int total;
   int bad;

   alu_issue_ctrl_if #(.XLEN(XLEN)) bus ();

   alu_issue_ctrl #(.XLEN(XLEN)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .alu_input1  (alu_input1),
      .alu_input2  (alu_input2),
      .alu_control (alu_control),
      .alu_result  (alu_result),
      .alu_zero    (alu_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      alu_result = '0;
      case (alu_control)
         4'b0000: alu_result = alu_input1 & alu_input2;
         4'b0001: alu_result = alu_input1 | alu_input2;
         4'b0010: alu_result = alu_input1 + alu_input2;
         4'b0110: alu_result = alu_input1 - alu_input2;
         4'b0111: alu_result = ($signed(alu_input1) < $signed(alu_input2)) ? 64'd1 : 64'd0;
         default: alu_result = '0;
      endcase
   end
   assign alu_zero = (alu_result == '0);

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] aluop, input logic [2:0] f3, input logic f7,
                       input logic [XLEN-1:0] op1, input logic [XLEN-1:0] op2);
      bus.req_valid    = 1'b1;
      bus.req_aluop    = aluop;
      bus.req_funct3   = f3;
      bus.req_funct7_5 = f7;
      bus.req_op1      = op1;
      bus.req_op2      = op2;
      tick();
      bus.req_valid    = 1'b0;
   endtask

   task automatic test_reset();
      reset            = 1'b1;
      bus.req_valid    = 1'b1;
      bus.req_aluop    = 2'b10;
      bus.req_funct3   = 3'b000;
      bus.req_funct7_5 = 1'b0;
      bus.req_op1      = 64'd5;
      bus.req_op2      = 64'd7;
      bus.rsp_ready    = 1'b1;
      tick();
      tick();
      total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
      total++; if (alu_input1 !== 64'd0 || alu_input2 !== 64'd0) begin bad++; $display("FAIL reset_alu_inputs got=%0h/%0h exp=0/0", alu_input1, alu_input2); end
      total++; if (alu_control !== 4'b0000) begin bad++; $display("FAIL reset_alu_control got=%b exp=0000", alu_control); end
      total++; if ({bus.rsp_result, bus.rsp_taken, bus.rsp_error} !== '0) begin bad++; $display("FAIL reset_rsp_fields got=%0h/%b/%b exp=0/0/0", bus.rsp_result, bus.rsp_taken, bus.rsp_error); end
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      tick();
      total++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL post_reset_idle got=%b/%b exp=1/0", bus.req_ready, bus.rsp_valid); end
   endtask

   task automatic test_add();
      bus.rsp_ready = 1'b1;
      send(2'b10, 3'b000, 1'b0, 64'd5, 64'd7);
      total++; if (alu_control !== 4'b0010) begin bad++; $display("FAIL add_control got=%b exp=0010", alu_control); end
      total++; if (alu_input1 !== 64'd5 || alu_input2 !== 64'd7) begin bad++; $display("FAIL add_operands got=%0d/%0d exp=5/7", alu_input1, alu_input2); end
      total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin bad++; $display("FAIL add_exec_state got=%b/%b exp=0/0", bus.rsp_valid, bus.req_ready); end
      tick();
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL add_rsp_valid got=%b exp=1", bus.rsp_valid); end
      total++; if (bus.rsp_result !== 64'd12) begin bad++; $display("FAIL add_result got=%0d exp=12", bus.rsp_result); end
      total++; if (bus.rsp_taken !== 1'b0 || bus.rsp_error !== 1'b0) begin bad++; $display("FAIL add_flags got=%b/%b exp=0/0", bus.rsp_taken, bus.rsp_error); end
      tick();
      total++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL add_release got=%b/%b exp=1/0", bus.req_ready, bus.rsp_valid); end
   endtask

   logic [2:0]      br_f3   [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
   logic [XLEN-1:0] br_op1  [4] = '{64'd3, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
   logic [XLEN-1:0] br_op2  [4] = '{64'd3, 64'd3, 64'd1, 64'd1};
   logic [3:0]      br_ctl  [4] = '{4'b0110, 4'b0110, 4'b0111, 4'b0111};
   logic [XLEN-1:0] br_res  [4] = '{64'd0, 64'd0, 64'd1, 64'd1};
   logic            br_tak  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

   task automatic test_branches();
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(2'b01, br_f3[i], 1'b0, br_op1[i], br_op2[i]);
         total++; if (alu_control !== br_ctl[i]) begin bad++; $display("FAIL branch%0d_control got=%b exp=%b", i, alu_control, br_ctl[i]); end
         tick();
         total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b0) begin bad++; $display("FAIL branch%0d_valid got=%b/%b exp=1/0", i, bus.rsp_valid, bus.rsp_error); end
         total++; if (bus.rsp_result !== br_res[i]) begin bad++; $display("FAIL branch%0d_result got=%0h exp=%0h", i, bus.rsp_result, br_res[i]); end
         total++; if (bus.rsp_taken !== br_tak[i]) begin bad++; $display("FAIL branch%0d_taken got=%b exp=%b", i, bus.rsp_taken, br_tak[i]); end
         tick();
      end
   endtask

   logic [1:0] il_aluop [2] = '{2'b11, 2'b10};
   logic [2:0] il_f3    [2] = '{3'b000, 3'b001};

   task automatic test_illegal();
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         send(il_aluop[i], il_f3[i], 1'b0, 64'd9, 64'd2);
         total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL illegal%0d_valid got=%b exp=1", i, bus.rsp_valid); end
         total++; if (bus.rsp_error !== 1'b1) begin bad++; $display("FAIL illegal%0d_error got=%b exp=1", i, bus.rsp_error); end
         total++; if (bus.rsp_result !== 64'd0 || bus.rsp_taken !== 1'b0) begin bad++; $display("FAIL illegal%0d_fields got=%0h/%b exp=0/0", i, bus.rsp_result, bus.rsp_taken); end
         total++; if (alu_control !== 4'b0000 || alu_input1 !== 64'd9) begin bad++; $display("FAIL illegal%0d_alu got=%b/%0d exp=0000/9", i, alu_control, alu_input1); end
         tick();
         total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL illegal%0d_release got=%b exp=1", i, bus.req_ready); end
      end
   endtask

   task automatic test_back_to_back();
      bus.rsp_ready = 1'b0;
      send(2'b10, 3'b000, 1'b1, 64'd10, 64'd4);
      tick();
      bus.req_valid    = 1'b1;
      bus.req_aluop    = 2'b10;
      bus.req_funct3   = 3'b110;
      bus.req_funct7_5 = 1'b0;
      bus.req_op1      = 64'hF0;
      bus.req_op2      = 64'h0F;
      for (int i = 0; i < 5; i++) begin
         total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 64'd6) begin bad++; $display("FAIL bp%0d_hold got=%b/%0d exp=1/6", i, bus.rsp_valid, bus.rsp_result); end
         total++; if (bus.req_ready !== 1'b0 || alu_input1 !== 64'd10 || alu_control !== 4'b0110) begin bad++; $display("FAIL bp%0d_ignore got=%b/%0h/%b exp=0/a/0110", i, bus.req_ready, alu_input1, alu_control); end
         tick();
      end
      bus.rsp_ready = 1'b1;
      tick();
      total++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b/%b exp=1/0", bus.req_ready, bus.rsp_valid); end
      tick();
      bus.req_valid = 1'b0;
      total++; if (alu_control !== 4'b0001 || alu_input1 !== 64'hF0) begin bad++; $display("FAIL bp_second_accept got=%b/%0h exp=0001/f0", alu_control, alu_input1); end
      tick();
      total++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 64'hFF) begin bad++; $display("FAIL bp_second_result got=%b/%0h exp=1/ff", bus.rsp_valid, bus.rsp_result); end
      tick();
   endtask

   task automatic test_mid_reset();
      bus.rsp_ready = 1'b1;
      send(2'b10, 3'b111, 1'b0, 64'hF0, 64'h3C);
      total++; if (alu_control !== 4'b0000 || alu_input2 !== 64'h3C) begin bad++; $display("FAIL midrst_exec got=%b/%0h exp=0000/3c", alu_control, alu_input2); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL midrst_state got=%b/%b exp=0/1", bus.rsp_valid, bus.req_ready); end
      total++; if (alu_input1 !== 64'd0 || alu_input2 !== 64'd0 || alu_control !== 4'b0000) begin bad++; $display("FAIL midrst_alu got=%0h/%0h/%b exp=0/0/0000", alu_input1, alu_input2, alu_control); end
      total++; if ({bus.rsp_result, bus.rsp_taken, bus.rsp_error} !== '0) begin bad++; $display("FAIL midrst_rsp got=%0h/%b/%b exp=0/0/0", bus.rsp_result, bus.rsp_taken, bus.rsp_error); end
      tick();
      total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_rsp got=%b exp=0", bus.rsp_valid); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_add();
      test_branches();
      test_illegal();
      test_back_to_back();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
